// File: rtl/uk101_load_pkg.sv
// uk101_load_pkg: shared state encoding and ASCII constants for the load sequencer
package uk101_load_pkg;
  typedef enum logic [1:0] {LS_IDLE, LS_SEND, LS_GAP} load_state_t;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
endpackage

// File: rtl/ascii_load_sequencer_fifo.sv
// load_fifo: synchronous first-word-fall-through FIFO.
// Ports: wr_en/wr_data push, rd_en pops, rd_data shows the head, count/full/empty status.
// A push while full is accepted only when a pop happens in the same cycle.
module load_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic wr, rd;
  assign rd = rd_en & ~empty;
  assign wr = wr_en & (~full | rd);
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign rd_data = mem[rp_q];
  always_ff @(posedge clk) begin
    if (wr) mem[wp_q] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q + 1'b1;
      if (rd) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/ascii_load_sequencer.sv
// ascii_load_sequencer: paces ASCII text from the HPS download or UART into the ACIA RX register.
// Ports: clk_sys/reset; load_from selects file (0) or UART (1); ioctl_* download side with
// ioctl_wait back-pressure; uart_valid/uart_data; rx_ready/rx_strobe/rx_data to the ACIA;
// busy activity flag; overflow sticky drop flag.
module ascii_load_sequencer
  import uk101_load_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CHAR_GAP   = 2000,
  parameter int LINE_GAP   = 480000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       load_from,
  input  logic       ioctl_download,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_data,
  output logic       ioctl_wait,
  input  logic       uart_valid,
  input  logic [7:0] uart_data,
  input  logic       rx_ready,
  output logic       rx_strobe,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       overflow
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int GW = $clog2(LINE_GAP+1);
  load_state_t state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0] rx_data_q, wr_data, head;
  logic [CW-1:0] count;
  logic wr_en, pop, full, empty, wait_q, busy_q, ovf_q;
  // LF is stripped only from file downloads; the UART path is passed through verbatim.
  assign wr_data = load_from ? uart_data : ioctl_data;
  assign wr_en = load_from ? uart_valid : ioctl_wr & ioctl_download & (ioctl_data != ASCII_LF);
  assign pop = state_q == LS_SEND;
  load_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_sys), .rst(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(pop),
    .rd_data(head), .count(count), .full(full), .empty(empty)
  );
  // GAP leaves at gap==1 so that IDLE sees gap==0 on the next cycle, giving a strobe
  // spacing of exactly CHAR_GAP+1 (or LINE_GAP+1) cycles; the decrement saturates at 0.
  always_comb begin
    state_d = state_q;
    gap_d = gap_q;
    state_d = state_q == LS_IDLE ? ((~empty & rx_ready & (gap_q == '0)) ? LS_SEND : LS_IDLE)
            : state_q == LS_SEND ? LS_GAP
            : (gap_q <= GW'(1) ? LS_IDLE : LS_GAP);
    gap_d = pop ? (head == ASCII_CR ? GW'(LINE_GAP-1) : GW'(CHAR_GAP-1))
          : (state_q == LS_GAP && gap_q != '0) ? gap_q - 1'b1 : gap_q;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= LS_IDLE;
      gap_q <= '0;
      rx_data_q <= 8'h00;
      wait_q <= 1'b0;
      busy_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q <= gap_d;
      if (pop) rx_data_q <= head;
      wait_q <= ~load_from & (count >= CW'(FIFO_DEPTH-2));
      busy_q <= ioctl_download | ~empty | (state_q != LS_IDLE);
      ovf_q <= ovf_q | (wr_en & full & ~pop);
    end
  end
  // The head is shown alongside the strobe; afterwards the captured copy holds the value.
  assign rx_strobe = pop;
  assign rx_data = pop ? head : rx_data_q;
  assign ioctl_wait = wait_q;
  assign busy = busy_q;
  assign overflow = ovf_q;
endmodule
